// File: rtl/sp_rom_arbiter_if.sv
// Bus bundle between two burst requesters, the ROM arbiter and the ROM.
// slave: arbiter side; master: requesters + ROM side.
interface sp_rom_arbiter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int BURST_WIDTH   = 4
) ();
  logic                     m0_req;
  logic [ADDRESS_WIDTH-1:0] m0_addr;
  logic [BURST_WIDTH-1:0]   m0_len;
  logic                     m0_grant;
  logic                     m0_valid;
  logic [DATA_WIDTH-1:0]    m0_data;
  logic                     m0_done;

  logic                     m1_req;
  logic [ADDRESS_WIDTH-1:0] m1_addr;
  logic [BURST_WIDTH-1:0]   m1_len;
  logic                     m1_grant;
  logic                     m1_valid;
  logic [DATA_WIDTH-1:0]    m1_data;
  logic                     m1_done;

  logic [ADDRESS_WIDTH-1:0] rom_address;
  logic                     rom_ren;
  logic                     rom_cen;
  logic [DATA_WIDTH-1:0]    rom_data;

  modport slave (
    input  m0_req, m0_addr, m0_len,
    output m0_grant, m0_valid, m0_data, m0_done,
    input  m1_req, m1_addr, m1_len,
    output m1_grant, m1_valid, m1_data, m1_done,
    output rom_address, rom_ren, rom_cen,
    input  rom_data
  );

  modport master (
    output m0_req, m0_addr, m0_len,
    input  m0_grant, m0_valid, m0_data, m0_done,
    output m1_req, m1_addr, m1_len,
    input  m1_grant, m1_valid, m1_data, m1_done,
    input  rom_address, rom_ren, rom_cen,
    output rom_data
  );
endinterface

// File: rtl/sp_rom_arbiter.sv
// Two-master burst arbiter for a negedge-read single-port ROM.
// Ports: clk, rst_n (sync, active-low), bus (sp_rom_arbiter_if.slave):
//   mX_req/addr/len in, mX_grant/valid/data/done out,
//   rom_address/ren/cen out, rom_data in.
// Option: SP_ROM_ARB_ROUND_ROBIN_EN selects round-robin on ties
//   (default build: fixed priority, master 0 first).
module sp_rom_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int BURST_WIDTH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  sp_rom_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                   r_state;
  logic                     r_owner;
  logic [BURST_WIDTH-1:0]   r_cnt;
  logic [ADDRESS_WIDTH-1:0] r_rom_addr;
  logic                     r_rom_ren;
  logic                     r_rom_cen;
  logic                     r_m0_grant;
  logic                     r_m0_valid;
  logic                     r_m0_done;
  logic [DATA_WIDTH-1:0]    r_m0_data;
  logic                     r_m1_grant;
  logic                     r_m1_valid;
  logic                     r_m1_done;
  logic [DATA_WIDTH-1:0]    r_m1_data;

  logic                     w_any;
  logic                     w_win;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [BURST_WIDTH-1:0]   w_len;

  assign w_any = bus.m0_req | bus.m1_req;

`ifdef SP_ROM_ARB_ROUND_ROBIN_EN
  // Master favoured on the next tie; 0 out of reset.
  logic r_rr_ptr;

  assign w_win = (bus.m0_req & bus.m1_req) ? r_rr_ptr
                                           : bus.m1_req;
`else
  // w_win=1 selects master 1; only meaningful when w_any.
  assign w_win = ~bus.m0_req;
`endif

  assign w_addr = w_win ? bus.m1_addr : bus.m0_addr;
  assign w_len  = w_win ? bus.m1_len  : bus.m0_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_rom_ren  <= 1'b0;
      r_rom_cen  <= 1'b0;
      r_m0_grant <= 1'b0;
      r_m0_valid <= 1'b0;
      r_m0_done  <= 1'b0;
      r_m0_data  <= '0;
      r_m1_grant <= 1'b0;
      r_m1_valid <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m1_data  <= '0;
`ifdef SP_ROM_ARB_ROUND_ROBIN_EN
      r_rr_ptr   <= 1'b0;
`endif
    end else begin
      r_m0_valid <= 1'b0;
      r_m1_valid <= 1'b0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_m0_grant <= ~w_win;
            r_m1_grant <= w_win;
            r_rom_addr <= w_addr;
            r_rom_ren  <= 1'b1;
            r_rom_cen  <= 1'b1;
            r_cnt      <= w_len;
            r_owner    <= w_win;
`ifdef SP_ROM_ARB_ROUND_ROBIN_EN
            r_rr_ptr   <= ~w_win;
`endif
            r_state    <= READ;
          end
        end
        READ: begin
          // ROM output was refreshed at the preceding negedge.
          if (r_owner) begin
            r_m1_valid <= 1'b1;
            r_m1_data  <= bus.rom_data;
          end else begin
            r_m0_valid <= 1'b1;
            r_m0_data  <= bus.rom_data;
          end
          if (r_cnt == '0) begin
            r_m0_grant <= 1'b0;
            r_m1_grant <= 1'b0;
            r_rom_ren  <= 1'b0;
            r_rom_cen  <= 1'b0;
            r_m0_done  <= ~r_owner;
            r_m1_done  <= r_owner;
            r_state    <= IDLE;
          end else begin
            // Natural wrap at the top of the address space.
            r_rom_addr <= r_rom_addr + ADDRESS_WIDTH'(1);
            r_cnt      <= r_cnt - BURST_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m0_grant    = r_m0_grant;
  assign bus.m0_valid    = r_m0_valid;
  assign bus.m0_data     = r_m0_data;
  assign bus.m0_done     = r_m0_done;
  assign bus.m1_grant    = r_m1_grant;
  assign bus.m1_valid    = r_m1_valid;
  assign bus.m1_data     = r_m1_data;
  assign bus.m1_done     = r_m1_done;
  assign bus.rom_address = r_rom_addr;
  assign bus.rom_ren     = r_rom_ren;
  assign bus.rom_cen     = r_rom_cen;

endmodule
